trng_entropy_collector: RTL and testbench

Upstream stage of the 128-bit TRNG conditioning path. It samples a pre-synchronized raw noise bit stream and assembles one 512-bit entropy block. It runs the continuous health tests on every accepted bit: a repetition count test and an adaptive proportion test. A healthy block is presented on `data_out` for the conditioner's 512-bit `data_in`.

---
 rtl/trng_pkg.sv | 32 +++
 rtl/trng_entropy_collector_if.sv | 22 ++
 rtl/trng_health_test.sv | 50 +++++
 rtl/trng_entropy_collector.sv | 90 +++++++++
 tb/tb_trng_entropy_collector.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG entropy collector.
package trng_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2,
    StFail = 2'd3
  } state_e;

  localparam int unsigned DefBlockBits = 512;
  localparam int unsigned DefRctCutoff = 32;
  localparam int unsigned DefAptCutoff = 330;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  function automatic int unsigned bit_cnt_width(input int unsigned block_bits);
    return cnt_width(block_bits);
  endfunction

  function automatic int unsigned run_cnt_width(input int unsigned rct_cutoff);
    return cnt_width(rct_cutoff);
  endfunction

  function automatic int unsigned apt_cnt_width(input int unsigned apt_cutoff);
    return cnt_width(apt_cutoff);
  endfunction

endpackage

// File: rtl/trng_entropy_collector_if.sv
// Control, noise input and block output bundle of the entropy collector.
interface trng_entropy_collector_if #(
  parameter int unsigned P_BLOCK_BITS = trng_pkg::DefBlockBits
);
  logic                    Collect_Go;
  logic                    raw_bit;
  logic                    raw_valid;
  logic                    Busy;
  logic                    Collect_Done;
  logic                    Health_Fail;
  logic [P_BLOCK_BITS-1:0] data_out;

  modport master (
    output Collect_Go, raw_bit, raw_valid,
    input  Busy, Collect_Done, Health_Fail, data_out
  );

  modport slave (
    input  Collect_Go, raw_bit, raw_valid,
    output Busy, Collect_Done, Health_Fail, data_out
  );
endinterface

// File: rtl/trng_health_test.sv
// Continuous repetition count and adaptive proportion tests on the accepted bit stream.
module trng_health_test
  import trng_pkg::*;
#(
  parameter int unsigned P_RCT_CUTOFF = DefRctCutoff,
  parameter int unsigned P_APT_CUTOFF = DefAptCutoff
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic first_bit,
  output logic fail
);
  localparam int unsigned RunW = run_cnt_width(P_RCT_CUTOFF);
  localparam int unsigned AptW = apt_cnt_width(P_APT_CUTOFF);

  logic            prev_bit_q, ref_bit_q;
  logic [RunW-1:0] run_q, run_d;
  logic [AptW-1:0] apt_q, apt_d;

  always_comb begin
    run_d = RunW'(1);
    apt_d = apt_q;
    if (first_bit) begin
      apt_d = AptW'(1);
    end else begin
      if (bit_in == prev_bit_q) run_d = run_q + RunW'(1);
      if (bit_in == ref_bit_q)  apt_d = apt_q + AptW'(1);
    end
  end

  // Judged on the incoming bit so the FSM can leave FILL on that same bit.
  assign fail = bit_valid && ((run_d == RunW'(P_RCT_CUTOFF)) || (apt_d == AptW'(P_APT_CUTOFF)));

  always_ff @(posedge clk) begin
    if (Reset || clear) begin
      prev_bit_q <= 1'b0;
      ref_bit_q  <= 1'b0;
      run_q      <= '0;
      apt_q      <= '0;
    end else if (bit_valid) begin
      prev_bit_q <= bit_in;
      run_q      <= run_d;
      apt_q      <= apt_d;
      if (first_bit) ref_bit_q <= bit_in;
    end
  end
endmodule

// File: rtl/trng_entropy_collector.sv
// Assembles one health-tested entropy block from the raw noise stream, MSB first.
module trng_entropy_collector
  import trng_pkg::*;
#(
  parameter int unsigned P_BLOCK_BITS = DefBlockBits,
  parameter int unsigned P_RCT_CUTOFF = DefRctCutoff,
  parameter int unsigned P_APT_CUTOFF = DefAptCutoff
) (
  input logic                     clk,
  input logic                     Reset,
  trng_entropy_collector_if.slave bus
);
  localparam int unsigned CntW = bit_cnt_width(P_BLOCK_BITS);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [P_BLOCK_BITS-1:0] data_q, data_d;
  logic                    fail_q, fail_d;
  logic                    start, accept, first_bit, last_bit, health_fail;

  assign start     = (state_q == StIdle) && bus.Collect_Go;
  assign accept    = (state_q == StFill) && bus.raw_valid;
  assign first_bit = (bit_cnt_q == '0);
  assign last_bit  = (bit_cnt_q == CntW'(P_BLOCK_BITS - 1));

  trng_health_test #(
    .P_RCT_CUTOFF(P_RCT_CUTOFF),
    .P_APT_CUTOFF(P_APT_CUTOFF)
  ) u_health (
    .clk      (clk),
    .Reset    (Reset),
    .clear    (start),
    .bit_valid(accept),
    .bit_in   (bus.raw_bit),
    .first_bit(first_bit),
    .fail     (health_fail)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    fail_d    = fail_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Collect_Go) begin
          state_d   = StFill;
          bit_cnt_d = '0;
          data_d    = '0;
          fail_d    = 1'b0;
        end
      end
      StFill: begin
        if (bus.raw_valid) begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
          data_d    = {data_q[P_BLOCK_BITS-2:0], bus.raw_bit};
          // A failing bit wins over completion and scrubs the partial block.
          if (health_fail) begin
            state_d = StFail;
            data_d  = '0;
            fail_d  = 1'b1;
          end else if (last_bit) begin
            state_d = StDone;
          end
        end
      end
      StDone, StFail: state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      data_q    <= '0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      fail_q    <= fail_d;
    end
  end

  assign bus.Busy         = (state_q == StFill);
  assign bus.Collect_Done = (state_q == StDone) || (state_q == StFail);
  assign bus.Health_Fail  = fail_q;
  assign bus.data_out     = data_q;
endmodule

// File: tb/tb_trng_entropy_collector.sv
// Scoreboard bench: the stimulus task models each block and queues the expected outcome.
module tb_trng_entropy_collector;
  localparam int unsigned BB  = 512;
  localparam int          RCT = 32;
  localparam int          APT = 330;

  typedef struct {
    logic          fail;
    logic [BB-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   last_done_cyc = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  trng_entropy_collector_if #(.P_BLOCK_BITS(BB)) bus ();

  trng_entropy_collector #(
    .P_BLOCK_BITS(BB),
    .P_RCT_CUTOFF(RCT),
    .P_APT_CUTOFF(APT)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pat_bit(input int mode, input int i);
    case (mode)
      0:       return (i % 2) == 0;
      1:       return 1'b1;
      default: return (i % 32) != 31;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!Reset && bus.Collect_Done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("health_fail", bus.Health_Fail, mon_e.fail);
        check("data_out", bus.data_out, mon_e.data);
        check("done_cycle", cyc, mon_e.cyc);
        check("busy_at_done", bus.Busy, 0);
        last_done_cyc = cyc;
      end
    end
  end

  task automatic run_block(input int mode, input int every, input bit go_noise,
                           input int reset_after, input int exp_lat, input bit go_at_done);
    int t, acc, slot, run, apt;
    bit b, prev, refb, fin, mfail;
    logic [BB-1:0] mdata;
    @(posedge clk); #1;
    t = cyc;
    bus.Collect_Go = 1'b1;
    @(posedge clk); #1;
    bus.Collect_Go = 1'b0;
    check("busy_start", bus.Busy, 1);
    check("fail_cleared", bus.Health_Fail, 0);
    check("data_cleared", bus.data_out, 0);
    acc = 0; slot = 0; run = 0; apt = 0;
    prev = 0; refb = 0; fin = 0; mfail = 0; mdata = '0;
    while (!fin) begin
      if (reset_after != 0 && acc == reset_after) begin
        bus.raw_valid = 1'b0;
        Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        check("rst_busy", bus.Busy, 0);
        check("rst_data", bus.data_out, 0);
        check("rst_done", bus.Collect_Done, 0);
        return;
      end
      if (slot % every == 0) begin
        b = pat_bit(mode, acc);
        bus.raw_valid  = 1'b1;
        bus.raw_bit    = b;
        bus.Collect_Go = 1'b0;
        if (acc == 0) begin
          run = 1; apt = 1; refb = b;
        end else begin
          run = (b == prev) ? run + 1 : 1;
          if (b == refb) apt++;
        end
        prev  = b;
        mdata = {mdata[BB-2:0], b};
        acc++;
        if (run == RCT || apt == APT) begin
          mfail = 1'b1; mdata = '0; fin = 1'b1;
        end else if (acc == BB) begin
          fin = 1'b1;
        end
      end else begin
        bus.raw_valid  = 1'b0;
        bus.Collect_Go = go_noise;
      end
      slot++;
      if (fin) exp_q.push_back('{mfail, mdata, cyc + 1});
      @(posedge clk); #1;
    end
    bus.raw_valid  = 1'b0;
    bus.Collect_Go = go_at_done;
    @(posedge clk); #1;
    bus.Collect_Go = 1'b0;
    if (go_at_done) check("go_at_done_ignored", bus.Busy, 0);
    for (int k = 0; k < 8 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      check("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    if (exp_lat != 0) check("latency", last_done_cyc - t, exp_lat);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset          = 1'b1;
    bus.Collect_Go = 1'b0;
    bus.raw_bit    = 1'b0;
    bus.raw_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Reset = 1'b0;
    check("reset_busy", bus.Busy, 0);
    check("reset_done", bus.Collect_Done, 0);
    check("reset_fail", bus.Health_Fail, 0);
    check("reset_data", bus.data_out, 0);

    run_block(0, 1, 1'b0, 0, 513, 1'b1);
    run_block(1, 1, 1'b0, 0, 33, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("fail_held", bus.Health_Fail, 1);
    check("fail_data_zero", bus.data_out, 0);
    run_block(0, 1, 1'b0, 0, 513, 1'b0);
    run_block(2, 1, 1'b0, 0, 341, 1'b0);
    run_block(0, 3, 1'b1, 0, 1535, 1'b0);
    run_block(0, 1, 1'b0, 200, 0, 1'b0);
    run_block(0, 1, 1'b0, 0, 513, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("hold_data", bus.data_out, {256{2'b10}});
    check("hold_fail", bus.Health_Fail, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
